zx_keyboard: RTL and testbench
==============================

# zx_keyboard

PS/2 keyboard front end for the Spectrum core, directly downstream of the MiST I/O block's `ps2_kbd_clk`/`ps2_kbd_data` pair. It deserialises PS/2 frames and decodes the set-2 make, break and E0 prefixes. It keeps an 8×5 Spectrum key matrix and answers ULA port-0xFE row reads. It also exports raw scancodes, F1–F12 held state and a Ctrl+Alt+Del reset request.

## Interface
- `TIMEOUT`, default 4096: clk_sys cycles without a PS/2 falling edge before a partial frame is abandoned.
- `clk_sys` in 1: system clock; everything is synchronous to it.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_kbd_clk` in 1: PS/2 clock from the I/O block; asynchronous.
- `ps2_kbd_data` in 1: PS/2 data from the I/O block; asynchronous.
- `addr` in 16: CPU address. Row r is selected when `addr[8+r]`=0.
- `key_data` out 5: active-low column bits for the selected rows.
- `kbd_code` out 8: last valid received byte.
- `kbd_strobe` out 1: one-cycle pulse when `kbd_code` updates.
- `kbd_err` out 1: one-cycle pulse on a framing, parity or timeout error.
- `fkeys` out 12: held state of F1..F12 (bit0 = F1).
- `kbd_reset` out 1: high while Ctrl, Alt and Del are all held.

## Operation
- **Synchronisation:** clk and data each pass through a 2-FF synchroniser. A falling edge is the synced clk going 1→0.
- **Receiver states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall with data=0 → DATA (bit count 0). A fall with data=1 is ignored.
  - DATA: shift LSB first; after 8 bits → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: if stop=1 and odd parity holds, load `kbd_code` and pulse `kbd_strobe`. Otherwise pulse `kbd_err`. Either way → IDLE.
  - Timeout: outside IDLE, a counter reaching `TIMEOUT` → IDLE with a `kbd_err` pulse. The counter clears on every fall.
- **Decoder** (consumes each strobe):
  - E0 sets `ext`; F0 sets `rel`. Both are sticky until the next non-prefix byte.
  - E1 is ignored.
  - AA (keyboard BAT) clears the matrix, `fkeys`, modifiers and flags.
  - FA, FE, EE, 00 and FF clear the flags only.
  - Any other byte is looked up using `ext`. It sets the mapped cell (make) or clears it (`rel`=1), then clears both flags.
- **Direct map** (row, bit). Unmapped codes change nothing except the flags.
  - 0x12 and 0x59 (shifts) → CS (0,0).
  - 0x14 and E0 14 (ctrls) → SS (7,1).
  - 0x1C A → (1,0); 0x5A Enter → (6,0); 0x29 Space → (7,0).
  - The letters, digits and the remaining Spectrum keys follow the standard Spectrum layout.
- **Modifiers:** Ctrl, Alt (11 / E0 11) and Del (71 / E0 71) are held separately. `kbd_reset` is registered from their AND.
- **F-keys:** 05, 06, 04, 0C, 03, 0B, 83, 0A, 01, 09, 78, 07 map to `fkeys[0..11]` as held bits.
- **Port read:** `key_data[i]` = NOT (OR over selected rows r of eff[r][i]). It is combinational from registered state. `addr`=0x00FE selects all rows.

## Timing
- **Reset values:** `key_data`=5'h1F, `kbd_code`=0, `kbd_strobe`=0, `kbd_err`=0, `fkeys`=0, `kbd_reset`=0. Receiver in IDLE; matrix, flags and modifiers cleared.
- **Receive latency:** `kbd_strobe` is high in the cycle after the clk_sys edge at which the synced stop-bit fall is detected.
- **Decode latency:** matrix, `fkeys` and `kbd_reset` update one cycle after `kbd_strobe`.
- **Port latency:** `key_data` follows `addr` with 0 cycles of latency and the matrix with 0 further cycles.
- **Pulse rules:** `kbd_strobe` and `kbd_err` never assert together. Consecutive bytes are at least 11 PS/2 bit periods apart, so the decoder needs no backpressure.
- **Reset mid-frame:** the partial frame is discarded; there is no err pulse.

## Configuration
- `KBD_EXT_KEYS_EN` defined: compound keys are enabled.
  - Backspace 66 → CS+0.
  - Arrows E0 6B/72/75/74 → CS+5/6/7/8.
  - Esc 76 → CS+Space.
  - These are held in a separate virtual register, and eff = direct OR compound. Releasing an arrow therefore does not release a physically held Shift.
- `KBD_EXT_KEYS_EN` undefined: these codes are unmapped, and eff = direct.

## Structure
- **`zx_kbd_pkg`:**
  - row/bit localparams;
  - prefix codes (E0, F0, E1, AA);
  - F-key code list;
  - the scancode→(row, bit, valid) map function, taking `ext` as an input.
- **`ps2_rx_byte` sub-module:**
  - contents: synchronisers, receiver FSM and timeout counter;
  - outputs: `code`, `strobe`, `err`;
  - parameter: `TIMEOUT`.
- **`zx_keyboard`:** holds the decoder, matrix, modifiers and the port-read logic.

## Test plan
- **Reset:** assert `reset_n`=0 with any `addr` → `key_data`=1F, `fkeys`=0, and no strobe until the first frame.
- **Make/break:**
  - Send 1C with `addr`=FDFE → strobe with `kbd_code`=1C, then `key_data`=1E.
  - Send F0 1C → `key_data`=1F.
  - `addr`=7FFE stays 1F throughout.
- **Parity error:** send 1C with the parity bit inverted → one `kbd_err` pulse, no `kbd_strobe`, matrix unchanged, and the following valid frame 29 is decoded.
- **Compound key (`KBD_EXT_KEYS_EN`):**
  - Press 12, then E0 6B → `addr`=FEFE gives 1E and `addr`=F7FE gives 0F.
  - Send E0 F0 6B → F7FE gives 1F while FEFE stays 1E.
- **Ctrl+Alt+Del and F-keys:**
  - 14, 11, E0 71 → `kbd_reset`=1; E0 F0 71 → 0.
  - 83 → `fkeys[6]`=1.
- **Timeout:** drive 5 PS/2 bits, then idle for 5000 cycles → one `kbd_err`. A following full frame 29 → strobe with 29, and `addr`=7FFE gives 1E.

Source files
------------

// File: rtl/zx_kbd_pkg.sv
// Shared types and tables for the Spectrum PS/2 keyboard front end.
// Compound keys (zx_keyboard) are enabled by defining KBD_EXT_KEYS_EN.
package zx_kbd_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 5;

  localparam logic [2:0] ROW_CS  = 3'd0;
  localparam logic [2:0] ROW_NUM = 3'd3;
  localparam logic [2:0] ROW_DIG = 3'd4;
  localparam logic [2:0] ROW_SP  = 3'd7;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_REL   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_ALT   = 8'h11;
  localparam logic [7:0] SC_DEL   = 8'h71;

  // Element 0 is F1, element 11 is F12.
  localparam logic [11:0][7:0] FKEY_CODES = {
    8'h07, 8'h78, 8'h09, 8'h01, 8'h0A, 8'h83,
    8'h0B, 8'h03, 8'h0C, 8'h04, 8'h06, 8'h05
  };

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } key_loc_t;

  function automatic key_loc_t loc(input logic [2:0] r, input logic [2:0] c);
    return '{valid: 1'b1, row: r, col: c};
  endfunction

  function automatic key_loc_t map_key(input logic [7:0] code, input logic ext);
    key_loc_t k;
    k = '0;
    case ({ext, code})
      9'h012, 9'h059: k = loc(3'd0, 3'd0);
      9'h01A: k = loc(3'd0, 3'd1);
      9'h022: k = loc(3'd0, 3'd2);
      9'h021: k = loc(3'd0, 3'd3);
      9'h02A: k = loc(3'd0, 3'd4);
      9'h01C: k = loc(3'd1, 3'd0);
      9'h01B: k = loc(3'd1, 3'd1);
      9'h023: k = loc(3'd1, 3'd2);
      9'h02B: k = loc(3'd1, 3'd3);
      9'h034: k = loc(3'd1, 3'd4);
      9'h015: k = loc(3'd2, 3'd0);
      9'h01D: k = loc(3'd2, 3'd1);
      9'h024: k = loc(3'd2, 3'd2);
      9'h02D: k = loc(3'd2, 3'd3);
      9'h02C: k = loc(3'd2, 3'd4);
      9'h016: k = loc(3'd3, 3'd0);
      9'h01E: k = loc(3'd3, 3'd1);
      9'h026: k = loc(3'd3, 3'd2);
      9'h025: k = loc(3'd3, 3'd3);
      9'h02E: k = loc(3'd3, 3'd4);
      9'h045: k = loc(3'd4, 3'd0);
      9'h046: k = loc(3'd4, 3'd1);
      9'h03E: k = loc(3'd4, 3'd2);
      9'h03D: k = loc(3'd4, 3'd3);
      9'h036: k = loc(3'd4, 3'd4);
      9'h04D: k = loc(3'd5, 3'd0);
      9'h044: k = loc(3'd5, 3'd1);
      9'h043: k = loc(3'd5, 3'd2);
      9'h03C: k = loc(3'd5, 3'd3);
      9'h035: k = loc(3'd5, 3'd4);
      9'h05A, 9'h15A: k = loc(3'd6, 3'd0);
      9'h04B: k = loc(3'd6, 3'd1);
      9'h042: k = loc(3'd6, 3'd2);
      9'h03B: k = loc(3'd6, 3'd3);
      9'h033: k = loc(3'd6, 3'd4);
      9'h029: k = loc(3'd7, 3'd0);
      9'h014, 9'h114: k = loc(3'd7, 3'd1);
      9'h03A: k = loc(3'd7, 3'd2);
      9'h031: k = loc(3'd7, 3'd3);
      9'h032: k = loc(3'd7, 3'd4);
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: input synchronisers, frame FSM and inter-bit timeout.
module ps2_rx_byte
  import zx_kbd_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       strobe_o,
  output logic       err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_prev_q;
  logic       fall, bit_in;

  rx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] code_q, code_d;
  logic       strobe_q, strobe_d;
  logic       err_q, err_d;

  // Synchronisers idle high so reset release never fakes a falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RX_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    tmo_d    = tmo_q;
    code_d   = code_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        RX_IDLE: begin
          if (!bit_in) begin
            state_d = RX_DATA;
            cnt_d   = '0;
          end
        end
        RX_DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = bit_in;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (bit_in && (^{shift_q, par_q})) begin
            code_d   = shift_q;
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE) begin
      if (tmo_q == TW'(TIMEOUT)) begin
        state_d = RX_IDLE;
        tmo_d   = '0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign code_o   = code_q;
  assign strobe_o = strobe_q;
  assign err_o    = err_q;

endmodule

// File: rtl/zx_keyboard.sv
// PS/2 set-2 decoder into the 8x5 Spectrum matrix with port-0xFE row reads.
// Define KBD_EXT_KEYS_EN to add compound keys (Backspace, arrows, Esc).
module zx_keyboard #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  input  logic [15:0] addr,
  output logic [4:0]  key_data,
  output logic [7:0]  kbd_code,
  output logic        kbd_strobe,
  output logic        kbd_err,
  output logic [11:0] fkeys,
  output logic        kbd_reset
);
  import zx_kbd_pkg::*;

  logic [7:0] rx_code;
  logic       rx_strobe, rx_err;

  ps2_rx_byte #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk_i      (clk_sys),
    .rst_ni     (reset_n),
    .ps2_clk_i  (ps2_kbd_clk),
    .ps2_data_i (ps2_kbd_data),
    .code_o     (rx_code),
    .strobe_o   (rx_strobe),
    .err_o      (rx_err)
  );

  logic [ROWS-1:0][COLS-1:0] mat_q, mat_d, eff;
  logic [11:0] fkeys_q, fkeys_d;
  logic        ext_q, ext_d, rel_q, rel_d;
  logic        ctrl_q, ctrl_d, alt_q, alt_d, del_q, del_d;
  logic        kbd_reset_q, kbd_reset_d;
  key_loc_t    kloc;
`ifdef KBD_EXT_KEYS_EN
  logic [5:0]  comp_q, comp_d;
  logic [ROWS-1:0][COLS-1:0] comp_mat;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mat_q       <= '0;
      fkeys_q     <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      ctrl_q      <= 1'b0;
      alt_q       <= 1'b0;
      del_q       <= 1'b0;
      kbd_reset_q <= 1'b0;
`ifdef KBD_EXT_KEYS_EN
      comp_q      <= '0;
`endif
    end else begin
      mat_q       <= mat_d;
      fkeys_q     <= fkeys_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      ctrl_q      <= ctrl_d;
      alt_q       <= alt_d;
      del_q       <= del_d;
      kbd_reset_q <= kbd_reset_d;
`ifdef KBD_EXT_KEYS_EN
      comp_q      <= comp_d;
`endif
    end
  end

  always_comb begin
    mat_d   = mat_q;
    fkeys_d = fkeys_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    ctrl_d  = ctrl_q;
    alt_d   = alt_q;
    del_d   = del_q;
`ifdef KBD_EXT_KEYS_EN
    comp_d  = comp_q;
`endif
    kloc    = map_key(rx_code, ext_q);
    if (rx_strobe) begin
      case (rx_code)
        SC_EXT:   ext_d = 1'b1;
        SC_REL:   rel_d = 1'b1;
        SC_PAUSE: begin end
        SC_BAT: begin
          mat_d   = '0;
          fkeys_d = '0;
          ctrl_d  = 1'b0;
          alt_d   = 1'b0;
          del_d   = 1'b0;
          ext_d   = 1'b0;
          rel_d   = 1'b0;
`ifdef KBD_EXT_KEYS_EN
          comp_d  = '0;
`endif
        end
        8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
        default: begin
          if (kloc.valid) mat_d[kloc.row][kloc.col] = ~rel_q;
          for (int i = 0; i < 12; i++) begin
            if (rx_code == FKEY_CODES[i]) fkeys_d[i] = ~rel_q;
          end
          if (rx_code == SC_CTRL) ctrl_d = ~rel_q;
          if (rx_code == SC_ALT)  alt_d  = ~rel_q;
          if (rx_code == SC_DEL)  del_d  = ~rel_q;
`ifdef KBD_EXT_KEYS_EN
          case ({ext_q, rx_code})
            9'h066: comp_d[0] = ~rel_q;
            9'h16B: comp_d[1] = ~rel_q;
            9'h172: comp_d[2] = ~rel_q;
            9'h175: comp_d[3] = ~rel_q;
            9'h174: comp_d[4] = ~rel_q;
            9'h076: comp_d[5] = ~rel_q;
            default: begin end
          endcase
`endif
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
      endcase
    end
    kbd_reset_d = ctrl_d & alt_d & del_d;
  end

`ifdef KBD_EXT_KEYS_EN
  // Compound keys live apart from the direct matrix so an arrow release
  // cannot drop a physically held Caps Shift.
  always_comb begin
    comp_mat                 = '0;
    comp_mat[ROW_CS][0]      = |comp_q;
    comp_mat[ROW_DIG][0]     = comp_q[0];
    comp_mat[ROW_NUM][4]     = comp_q[1];
    comp_mat[ROW_DIG][4]     = comp_q[2];
    comp_mat[ROW_DIG][3]     = comp_q[3];
    comp_mat[ROW_DIG][2]     = comp_q[4];
    comp_mat[ROW_SP][0]      = comp_q[5];
  end
  assign eff = mat_q | comp_mat;
`else
  assign eff = mat_q;
`endif

  always_comb begin
    logic [COLS-1:0] sel;
    sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!addr[8+r]) sel = sel | eff[r];
    end
    key_data = ~sel;
  end

  logic unused_addr;
  assign unused_addr = ^addr[7:0];

  assign kbd_code   = rx_code;
  assign kbd_strobe = rx_strobe;
  assign kbd_err    = rx_err;
  assign fkeys      = fkeys_q;
  assign kbd_reset  = kbd_reset_q;

endmodule

// File: tb/tb_zx_keyboard.sv
// Bench for zx_keyboard: PS/2 frame driver, strobe/err scoreboard, matrix reads.
module tb_zx_keyboard;

  localparam int HALF = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_kbd_clk = 1'b1;
  logic        ps2_kbd_data = 1'b1;
  logic [15:0] addr = 16'hFFFE;
  logic [4:0]  key_data;
  logic [7:0]  kbd_code;
  logic        kbd_strobe, kbd_err;
  logic [11:0] fkeys;
  logic        kbd_reset;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  zx_keyboard #(.TIMEOUT(4096)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .addr         (addr),
    .key_data     (key_data),
    .kbd_code     (kbd_code),
    .kbd_strobe   (kbd_strobe),
    .kbd_err      (kbd_err),
    .fkeys        (fkeys),
    .kbd_reset    (kbd_reset)
  );

  always #5 clk_sys = ~clk_sys;

  // Scoreboard: every strobe or err pulse must match the oldest expectation.
  always @(negedge clk_sys) begin
    if (kbd_strobe || kbd_err) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_event strobe=%0b err=%0b code=%02h", kbd_strobe, kbd_err, kbd_code);
      end else begin
        mon_e = exp_q.pop_front();
        if (kbd_strobe && kbd_err) begin
          errors = errors + 1;
          $display("FAIL pulse_overlap strobe=1 err=1 required one only");
        end else if (kbd_err !== mon_e.is_err || (!mon_e.is_err && kbd_code !== mon_e.code)) begin
          errors = errors + 1;
          $display("FAIL scoreboard got err=%0b code=%02h required err=%0b code=%02h",
                   kbd_err, kbd_code, mon_e.is_err, mon_e.code);
        end
      end
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_kbd_data = b;
    repeat (HALF) @(negedge clk_sys);
    ps2_kbd_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_kbd_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] c, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit((~^c) ^ bad_par);
    ps2_bit(1'b1);
    ps2_kbd_data = 1'b1;
    repeat (2 * HALF) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] c);
    exp_t e;
    e.is_err = 1'b0;
    e.code   = c;
    exp_q.push_back(e);
    send_raw(c, 1'b0);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.code   = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    addr = 16'h00FE;
    repeat (5) @(negedge clk_sys);
    #1;
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL rst_key_data got=%02h required=1F", key_data); end
    checks = checks + 1;
    if (fkeys !== 12'h000 || kbd_reset !== 1'b0 || kbd_code !== 8'h00) begin
      errors = errors + 1;
      $display("FAIL rst_outputs fkeys=%03h reset=%0b code=%02h required 000/0/00", fkeys, kbd_reset, kbd_code);
    end
    addr = 16'hFDFE;
    #1;
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL rst_row1 got=%02h required=1F", key_data); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
  endtask

  task automatic test_make_break();
    addr = 16'hFDFE;
    send_byte(8'h1C);
    checks = checks + 1;
    if (kbd_code !== 8'h1C) begin errors = errors + 1; $display("FAIL mb_code got=%02h required=1C", kbd_code); end
    checks = checks + 1;
    if (key_data !== 5'h1E) begin errors = errors + 1; $display("FAIL mb_press got=%02h required=1E", key_data); end
    addr = 16'h7FFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL mb_row7_held got=%02h required=1F", key_data); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL mb_row7_rel got=%02h required=1F", key_data); end
    addr = 16'hFDFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL mb_release got=%02h required=1F", key_data); end
  endtask

  task automatic test_parity_err();
    expect_err();
    send_raw(8'h1C, 1'b1);
    addr = 16'hFDFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL par_matrix got=%02h required=1F", key_data); end
    checks = checks + 1;
    if (exp_q.size() != 0) begin errors = errors + 1; $display("FAIL par_err_missing pending=%0d required=0", exp_q.size()); end
    send_byte(8'h29);
    addr = 16'h7FFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1E) begin errors = errors + 1; $display("FAIL par_next_frame got=%02h required=1E", key_data); end
    send_byte(8'hF0);
    send_byte(8'h29);
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL par_space_rel got=%02h required=1F", key_data); end
  endtask

  task automatic test_compound();
`ifdef KBD_EXT_KEYS_EN
    send_byte(8'h12);
    send_byte(8'hE0);
    send_byte(8'h6B);
    addr = 16'hFEFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1E) begin errors = errors + 1; $display("FAIL cmp_cs got=%02h required=1E", key_data); end
    addr = 16'hF7FE; #1;
    checks = checks + 1;
    if (key_data !== 5'h0F) begin errors = errors + 1; $display("FAIL cmp_5 got=%02h required=0F", key_data); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL cmp_5_rel got=%02h required=1F", key_data); end
    addr = 16'hFEFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1E) begin errors = errors + 1; $display("FAIL cmp_shift_kept got=%02h required=1E", key_data); end
    send_byte(8'hF0);
    send_byte(8'h12);
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL cmp_shift_rel got=%02h required=1F", key_data); end
`else
    send_byte(8'hE0);
    send_byte(8'h6B);
    addr = 16'hF7FE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL cmp_off_5 got=%02h required=1F", key_data); end
    addr = 16'hFEFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL cmp_off_cs got=%02h required=1F", key_data); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
`endif
  endtask

  task automatic test_cad_fkeys();
    send_byte(8'h14);
    send_byte(8'h11);
    checks = checks + 1;
    if (kbd_reset !== 1'b0) begin errors = errors + 1; $display("FAIL cad_partial got=%0b required=0", kbd_reset); end
    send_byte(8'hE0);
    send_byte(8'h71);
    checks = checks + 1;
    if (kbd_reset !== 1'b1) begin errors = errors + 1; $display("FAIL cad_set got=%0b required=1", kbd_reset); end
    addr = 16'h7FFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1D) begin errors = errors + 1; $display("FAIL cad_ss got=%02h required=1D", key_data); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h71);
    checks = checks + 1;
    if (kbd_reset !== 1'b0) begin errors = errors + 1; $display("FAIL cad_clear got=%0b required=0", kbd_reset); end
    send_byte(8'h83);
    checks = checks + 1;
    if (fkeys !== 12'h040) begin errors = errors + 1; $display("FAIL fkey_f7 got=%03h required=040", fkeys); end
    send_byte(8'hF0);
    send_byte(8'h83);
    checks = checks + 1;
    if (fkeys !== 12'h000) begin errors = errors + 1; $display("FAIL fkey_f7_rel got=%03h required=000", fkeys); end
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hF0);
    send_byte(8'h11);
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL cad_ss_rel got=%02h required=1F", key_data); end
  endtask

  task automatic test_multi_row();
    send_byte(8'h1C);
    send_byte(8'h29);
    send_byte(8'h1A);
    addr = 16'h00FE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1C) begin errors = errors + 1; $display("FAIL multi_all got=%02h required=1C", key_data); end
    addr = 16'hFDFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1E) begin errors = errors + 1; $display("FAIL multi_row1 got=%02h required=1E", key_data); end
    addr = 16'hFFFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL multi_none got=%02h required=1F", key_data); end
  endtask

  task automatic test_bat();
    send_byte(8'h05);
    checks = checks + 1;
    if (fkeys !== 12'h001) begin errors = errors + 1; $display("FAIL bat_f1 got=%03h required=001", fkeys); end
    send_byte(8'hF0);
    send_byte(8'hAA);
    checks = checks + 1;
    if (fkeys !== 12'h000) begin errors = errors + 1; $display("FAIL bat_fkeys got=%03h required=000", fkeys); end
    addr = 16'h00FE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL bat_matrix got=%02h required=1F", key_data); end
    send_byte(8'h1C);
    checks = checks + 1;
    if (key_data !== 5'h1E) begin errors = errors + 1; $display("FAIL bat_flags got=%02h required=1E", key_data); end
    send_byte(8'hF0);
    send_byte(8'h1C);
  endtask

  task automatic test_timeout();
    expect_err();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    repeat (5000) @(negedge clk_sys);
    checks = checks + 1;
    if (exp_q.size() != 0) begin errors = errors + 1; $display("FAIL tmo_err_missing pending=%0d required=0", exp_q.size()); end
    send_byte(8'h29);
    checks = checks + 1;
    if (kbd_code !== 8'h29) begin errors = errors + 1; $display("FAIL tmo_code got=%02h required=29", kbd_code); end
    addr = 16'h7FFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1E) begin errors = errors + 1; $display("FAIL tmo_space got=%02h required=1E", key_data); end
  endtask

  task automatic test_reset_midframe();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    reset_n = 1'b0;
    repeat (4) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    addr = 16'h7FFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1F) begin errors = errors + 1; $display("FAIL mid_rst_matrix got=%02h required=1F", key_data); end
    send_byte(8'h1C);
    checks = checks + 1;
    if (kbd_code !== 8'h1C) begin errors = errors + 1; $display("FAIL mid_rst_code got=%02h required=1C", kbd_code); end
    addr = 16'hFDFE; #1;
    checks = checks + 1;
    if (key_data !== 5'h1E) begin errors = errors + 1; $display("FAIL mid_rst_press got=%02h required=1E", key_data); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_parity_err();
    test_compound();
    test_cad_fkeys();
    test_multi_row();
    test_bat();
    test_timeout();
    test_reset_midframe();
    repeat (20) @(negedge clk_sys);
    checks = checks + 1;
    if (exp_q.size() != 0) begin errors = errors + 1; $display("FAIL final_pending got=%0d required=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
